// File: rtl/irq_request_latch.sv
// irq_request_latch: captures four request lines as pending bits, masks them,
// grants the highest eligible source (3 > 2 > 1 > 0) through a valid/ack
// handshake, and clears the served bit on acknowledge. An optional hold-off
// inserts idle cycles after each ack before the next grant.
module irq_request_latch #(
  parameter int EDGE_TRIG = 1,  // 1: pend on rising edge, 0: pend while high
  parameter int HOLDOFF   = 0   // idle cycles after each ack (0..15)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  input  logic       irq_ack,
  input  logic       overrun_clr,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] overrun
);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  // Counter reload value; only meaningful when a hold-off is configured.
  localparam logic [3:0] HOLD_LOAD = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [1:0] id_reg, id_next;
  logic       valid_reg, valid_next;
  logic [3:0] req_prev_reg;
  logic [3:0] pending_reg;
  logic [3:0] overrun_reg;

  logic [3:0] rise;
  logic [3:0] set_term;
  logic [3:0] clr;
  logic [3:0] eligible;
  logic [3:0] ovr_set;
  logic [1:0] enc;

  assign rise     = req_in & ~req_prev_reg;
  assign set_term = (EDGE_TRIG != 0) ? rise : req_in;
  assign eligible = pending_reg & ~mask;
  // An edge on an already-pending source that is not being served right now is lost.
  assign ovr_set  = (EDGE_TRIG != 0) ? (rise & pending_reg & ~clr) : 4'b0000;

  // Fixed-priority encoder, highest index wins.
  always_comb begin
    enc = 2'd0;
    if (eligible[3])      enc = 2'd3;
    else if (eligible[2]) enc = 2'd2;
    else if (eligible[1]) enc = 2'd1;
  end

  // Grant FSM: next state, latched ID/valid, hold-off count and served-bit clear.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    valid_next = valid_reg;
    clr        = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next = PRESENT;
          id_next    = enc;
          valid_next = 1'b1;
        end
      end
      PRESENT: begin
        // The grant is frozen until acknowledged; no re-arbitration here.
        if (irq_ack) begin
          clr        = 4'b0001 << id_reg;
          valid_next = 1'b0;
          if (HOLDOFF > 0) begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      id_reg    <= 2'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      id_reg    <= id_next;
      valid_reg <= valid_next;
    end
  end

  // Request capture: edge history, pending bits (set beats clear), sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_reg <= 4'b0000;
      pending_reg  <= 4'b0000;
      overrun_reg  <= 4'b0000;
    end else begin
      req_prev_reg <= req_in;
      pending_reg  <= (pending_reg & ~clr) | set_term;
      overrun_reg  <= (overrun_clr ? 4'b0000 : overrun_reg) | ovr_set;
    end
  end

  assign irq_valid = valid_reg;
  assign irq_id    = id_reg;
  assign pending   = pending_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: three configurations driven by shared stimulus,
// directed scenario checks followed by random traffic compared every cycle
// against a behavioural model of the pending/grant rules.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       irq_ack;
  logic       overrun_clr;

  logic       v_o [3];
  logic [1:0] id_o [3];
  logic [3:0] p_o [3];
  logic [3:0] o_o [3];

  int tests = 0;
  int fails = 0;

  // Instance configurations: edge/holdoff0, edge/holdoff3, level/holdoff0.
  localparam bit ED [3] = '{1'b1, 1'b1, 1'b0};
  localparam int HO [3] = '{0, 3, 0};

  always #5 clk = ~clk;

  irq_request_latch #(.EDGE_TRIG(1), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .irq_ack(irq_ack),
    .overrun_clr(overrun_clr), .irq_valid(v_o[0]), .irq_id(id_o[0]),
    .pending(p_o[0]), .overrun(o_o[0]));
  irq_request_latch #(.EDGE_TRIG(1), .HOLDOFF(3)) dut1 (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .irq_ack(irq_ack),
    .overrun_clr(overrun_clr), .irq_valid(v_o[1]), .irq_id(id_o[1]),
    .pending(p_o[1]), .overrun(o_o[1]));
  irq_request_latch #(.EDGE_TRIG(0), .HOLDOFF(0)) dut2 (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .irq_ack(irq_ack),
    .overrun_clr(overrun_clr), .irq_valid(v_o[2]), .irq_id(id_o[2]),
    .pending(p_o[2]), .overrun(o_o[2]));

  // Reference model state: grant flag, granted id, pending/overrun/previous
  // request bits and the number of idle cycles still owed after an ack.
  bit       m_valid [3];
  bit [1:0] m_id    [3];
  bit [3:0] m_pend  [3];
  bit [3:0] m_ovr   [3];
  bit [3:0] m_prev  [3];
  int       m_wait  [3];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance every model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_valid[k] = 0; m_id[k] = 0; m_pend[k] = 0;
        m_ovr[k] = 0; m_prev[k] = 0; m_wait[k] = 0;
      end else begin
        int       served;
        bit [3:0] elig, npend, oset;
        served = (m_valid[k] && irq_ack) ? int'(m_id[k]) : -1;
        elig   = m_pend[k] & ~mask;
        oset   = 0;
        for (int i = 0; i < 4; i++) begin
          bit r, s, c;
          r = req_in[i] && !m_prev[k][i];
          s = ED[k] ? r : req_in[i];
          c = (i == served);
          if (ED[k] && r && m_pend[k][i] && !c) oset[i] = 1;
          npend[i] = (m_pend[k][i] && !c) || s;
        end
        m_ovr[k] = (overrun_clr ? 4'b0 : m_ovr[k]) | oset;
        if (m_valid[k]) begin
          if (irq_ack) begin
            m_valid[k] = 0;
            m_wait[k]  = HO[k];
          end
        end else if (m_wait[k] > 0) begin
          m_wait[k]--;
        end else if (elig != 0) begin
          for (int i = 3; i >= 0; i--)
            if (elig[i]) begin m_id[k] = 2'(i); break; end
          m_valid[k] = 1;
        end
        m_pend[k] = npend;
        m_prev[k] = req_in;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid[%0d]", k),   {7'b0, v_o[k]},  {7'b0, m_valid[k]});
      chk($sformatf("id[%0d]", k),      {6'b0, id_o[k]}, {6'b0, m_id[k]});
      chk($sformatf("pending[%0d]", k), {4'b0, p_o[k]},  {4'b0, m_pend[k]});
      chk($sformatf("overrun[%0d]", k), {4'b0, o_o[k]},  {4'b0, m_ovr[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1; req_in = 0; mask = 0; irq_ack = 0; overrun_clr = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    int gap;
    int budget;
    rst = 1; req_in = 0; mask = 0; irq_ack = 0; overrun_clr = 0;

    // Reset state
    do_reset();
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state[%0d]", k), {v_o[k], id_o[k], p_o[k], 1'b0}, 8'h00);
    $display("[TB] reset checked");

    // T1: single pulse on source 0
    req_in = 4'b0001; tick();
    chk("t1_not_yet_valid", {7'b0, v_o[0]}, 8'h00);
    req_in = 4'b0000; tick();
    chk("t1_valid_id", {5'b0, v_o[0], id_o[0]}, 8'h04);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("t1_after_ack", {3'b0, v_o[0], p_o[0]}, 8'h00);
    $display("[TB] T1 single pulse done");

    // T2: sources 3 and 1 together, one idle cycle between grants
    do_reset();
    req_in = 4'b1010; tick(); req_in = 0; tick();
    chk("t2_first_id3", {5'b0, v_o[0], id_o[0]}, 8'h07);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("t2_gap_low", {7'b0, v_o[0]}, 8'h00);
    tick();
    chk("t2_second_id1", {5'b0, v_o[0], id_o[0]}, 8'h05);
    irq_ack = 1; tick(); irq_ack = 0;
    chk("t2_pending_clear", {4'b0, p_o[0]}, 8'h00);
    $display("[TB] T2 two sources done");

    // T3: no re-arbitration while presenting
    do_reset();
    req_in = 4'b0010; tick(); req_in = 0; tick();
    req_in = 4'b1000; tick(); req_in = 0; tick();
    chk("t3_id_held", {5'b0, v_o[0], id_o[0]}, 8'h05);
    chk("t3_pending", {4'b0, p_o[0]}, 8'h0a);
    irq_ack = 1; tick(); irq_ack = 0; tick();
    chk("t3_then_id3", {5'b0, v_o[0], id_o[0]}, 8'h07);
    $display("[TB] T3 no re-arbitration done");

    // T4: overrun set, cleared, and not set when the rise meets the ack
    do_reset();
    req_in = 4'b0100; tick(); req_in = 0; tick();
    req_in = 4'b0100; tick(); req_in = 0;
    chk("t4_overrun_set", {4'b0, o_o[0]}, 8'h04);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("t4_overrun_clr", {4'b0, o_o[0]}, 8'h00);
    req_in = 4'b0100; irq_ack = 1; tick(); req_in = 0; irq_ack = 0;
    chk("t4_coincident_pend", {7'b0, p_o[0][2]}, 8'h01);
    chk("t4_coincident_ovr", {4'b0, o_o[0]}, 8'h00);
    $display("[TB] T4 overrun done");

    // T5: masked source still pends
    do_reset();
    mask = 4'b1000; req_in = 4'b1001; tick(); req_in = 0; tick();
    chk("t5_masked_id0", {5'b0, v_o[0], id_o[0]}, 8'h04);
    chk("t5_pending", {4'b0, p_o[0]}, 8'h09);
    irq_ack = 1; tick(); irq_ack = 0; mask = 0; tick();
    chk("t5_unmasked_id3", {5'b0, v_o[0], id_o[0]}, 8'h07);
    $display("[TB] T5 mask done");

    // T6: hold-off of 3 gives four idle cycles; reset drops a live grant
    do_reset();
    req_in = 4'b1001; tick(); req_in = 0;
    budget = 0;
    while (!v_o[1] && budget < 20) begin tick(); budget++; end
    chk("t6_first_grant", {7'b0, v_o[1]}, 8'h01);
    irq_ack = 1; tick(); irq_ack = 0;
    gap = 0;
    while (!v_o[1] && gap < 20) begin gap++; tick(); end
    chk("t6_gap_cycles", 8'(gap), 8'd4);
    rst = 1; tick(); rst = 0;
    chk("t6_reset_in_present", {3'b0, v_o[1], p_o[1]}, 8'h00);
    $display("[TB] T6 holdoff gap=%0d", gap);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      req_in      = 4'($urandom) & 4'($urandom);
      mask        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      irq_ack     = 1'($urandom_range(0, 1));
      overrun_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    $display("[TB] random phase 1500 cycles done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
